lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 reset  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  single-cycle pulse from the LBP stage's finish output; begins one histogram pass.
REQ-004 lbp_rd_addr  output  6  LBP result memory read address, {y[2:0],x[2:0]}, 8x8 image.
REQ-005 lbp_rd_req  output  1  read request; high exactly in cycles carrying a valid lbp_rd_addr.
REQ-006 lbp_rd_data  input  8  LBP code; valid on the cycle after the cycle in which lbp_rd_req/lbp_rd_addr were registered high.
REQ-007 hist_valid  output  1  histogram bin offered downstream.
REQ-008 hist_bin  output  4  bin index of the offered bin.
REQ-009 hist_count  output  6  occurrence count of the offered bin, 0..36.
REQ-010 hist_ready  input  1  downstream accepts the bin on a clock edge where hist_valid and hist_ready are both high.
REQ-011 done  output  1  one-cycle pulse after bin 15 is accepted.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 FSM states SHALL be IDLE, READ, DRAIN, OUTPUT, DONE.
REQ-014 IDLE->READ on start=1; start SHALL be ignored in every other state.
REQ-015 On IDLE->READ, all 16 bin counters SHALL clear to 0 and the scan position SHALL be x=1, y=1.
REQ-016 READ SHALL issue one address per cycle, interior pixels only, raster order: x=1..6 within y, y=1..6 (9..14, 17..22, ... 49..54), 36 requests, no gaps.
REQ-017 Border addresses (x or y equal to 0 or 7) SHALL never appear with lbp_rd_req=1.
REQ-018 READ->DRAIN after address 54 is issued; DRAIN lasts 1 cycle to capture the final data, then ->OUTPUT.
REQ-019 Each returned code SHALL increment counter[lbp_rd_data[7:4]] by 1 in the cycle the data is valid; counters are 6 bits wide and cannot overflow, since the maximum count is 36.
REQ-020 First data valid: 1 cycle after the first request. Last increment: in DRAIN. READ+DRAIN = 37 cycles.
REQ-021 OUTPUT SHALL present bins 0..15 in ascending order with hist_valid=1. hist_bin and hist_count SHALL stay stable until accepted. After an accepting edge, the next bin SHALL be presented the following cycle.
REQ-022 hist_ready low SHALL stall indefinitely with no change in outputs. hist_ready high outside OUTPUT SHALL have no effect.
REQ-023 Acceptance of bin 15 -> DONE. DONE drives done=1 and hist_valid=0 for one cycle, then -> IDLE.
REQ-024 The sum of all 16 presented counts SHALL equal 36.

Reset
REQ-025 reset=1 SHALL immediately force IDLE and clear all counters, scan position and bin index.
REQ-026 Reset values: lbp_rd_addr=0, lbp_rd_req=0, hist_valid=0, hist_bin=0, hist_count=0, done=0.
REQ-027 Reset in any state aborts the pass; no partial histogram or done pulse follows. The next start SHALL produce a complete, correct histogram.

Verification
REQ-028 Memory all 8'h00, start pulse -> 36 reads at addresses 9..54 (interior only); bin0=36, bins 1..15=0; done pulse after the 16th accept.
REQ-029 Memory[{y,x}] = {1'b0,y,x,1'b0} -> bins 1..6 = 6 each; all other bins 0; sum 36.
REQ-030 hist_ready=1 except held low 5 cycles while bin 3 is offered -> bin 3 and its count stable all 5 cycles; bin 4 appears the cycle after ready returns.
REQ-031 start re-pulsed mid-READ and again in OUTPUT -> ignored: exactly 36 requests, unchanged histogram, a single done pulse.
REQ-032 reset pulsed at the 20th read -> next cycle all outputs 0 and lbp_rd_req=0; a new start yields the full expected histogram.
REQ-033 Monitor across all tests: lbp_rd_req never high with x or y in {0,7}; hist_valid never high outside OUTPUT.

Source files
------------

// File: rtl/lbp_hist.sv
// lbp_hist -- 16-bin histogram of the upper nibble of LBP codes over the
// interior 6x6 pixels of an 8x8 LBP result image.
//
// When start is pulsed, the block reads the 36 interior codes in raster order
// and counts each code in bin code[7:4]. It then offers bins 0..15 downstream
// using a valid/ready handshake, and finishes with a one-cycle done pulse.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        single-cycle pulse that begins a pass (honoured only in IDLE)
//   lbp_rd_addr  LBP memory read address {y[2:0],x[2:0]}
//   lbp_rd_req   read request, high only while lbp_rd_addr is valid
//   lbp_rd_data  LBP code, valid the cycle after its request
//   hist_valid   histogram bin offered
//   hist_bin     index of the offered bin
//   hist_count   count of the offered bin (0..36)
//   hist_ready   downstream accepts on an edge where hist_valid is also high
//   done         one-cycle pulse after bin 15 is accepted
module lbp_hist (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [5:0] lbp_rd_addr,
   output logic       lbp_rd_req,
   input  logic [7:0] lbp_rd_data,
   output logic       hist_valid,
   output logic [3:0] hist_bin,
   output logic [5:0] hist_count,
   input  logic       hist_ready,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, OUTPUT, DONE} state_t;

   localparam logic [5:0] FIRST_ADDR = 6'd9;   // x=1, y=1
   localparam logic [5:0] LAST_ADDR  = 6'd54;  // x=6, y=6

   state_t     state, state_next;
   logic       data_valid;        // lbp_rd_data carries a requested code this cycle
   logic [5:0] counter      [16];
   logic [5:0] counter_next [16];
   logic [5:0] addr_next;
   logic [3:0] bin_next;
   logic       last_addr;

   assign last_addr = (lbp_rd_addr == LAST_ADDR);
   assign bin_next  = hist_bin + 4'd1;

   // Raster step across the interior: x wraps from 6 back to 1 and y advances.
   always_comb begin
      if (lbp_rd_addr[2:0] == 3'd6)
         addr_next = {lbp_rd_addr[5:3] + 3'd1, 3'd1};
      else
         addr_next = {lbp_rd_addr[5:3], lbp_rd_addr[2:0] + 3'd1};
   end

   // State register.
   // NOTE: sequential state is updated with non-blocking assignments, so every
   // flop samples values from before the edge and the process order is irrelevant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   // NOTE: state_next is assigned a default first. Without that default, a path
   // that does not assign it would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = READ;
         READ:    if (last_addr) state_next = DRAIN;
         DRAIN:   state_next = OUTPUT;
         OUTPUT:  if (hist_ready && hist_bin == 4'd15) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counter update for this cycle. Clearing at pass start and counting the
   // returned data never occur together, because data only returns in READ/DRAIN.
   always_comb begin
      for (int i = 0; i < 16; i++)
         counter_next[i] = counter[i];
      if (state == IDLE && start) begin
         for (int i = 0; i < 16; i++)
            counter_next[i] = 6'd0;
      end else if (data_valid) begin
         counter_next[lbp_rd_data[7:4]] = counter[lbp_rd_data[7:4]] + 6'd1;
      end
   end

   // Registered counters and outputs.
   // NOTE: the 16 counters are reset explicitly. A reset must abort a pass and
   // leave no stale histogram, so this storage cannot be left uninitialised.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++)
            counter[i] <= 6'd0;
         data_valid  <= 1'b0;
         lbp_rd_addr <= 6'd0;
         lbp_rd_req  <= 1'b0;
         hist_valid  <= 1'b0;
         hist_bin    <= 4'd0;
         hist_count  <= 6'd0;
         done        <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++)
            counter[i] <= counter_next[i];
         data_valid <= lbp_rd_req;
         case (state)
            IDLE: begin
               if (start) begin
                  lbp_rd_addr <= FIRST_ADDR;
                  lbp_rd_req  <= 1'b1;
               end
            end
            READ: begin
               if (last_addr) begin
                  lbp_rd_req  <= 1'b0;
                  lbp_rd_addr <= 6'd0;
               end else begin
                  lbp_rd_addr <= addr_next;
               end
            end
            DRAIN: begin
               // The last code lands on this edge, so bin 0 comes from the
               // updated value rather than from the register.
               hist_valid <= 1'b1;
               hist_bin   <= 4'd0;
               hist_count <= counter_next[0];
            end
            OUTPUT: begin
               if (hist_ready) begin
                  if (hist_bin == 4'd15) begin
                     hist_valid <= 1'b0;
                     hist_count <= 6'd0;
                     done       <= 1'b1;
                  end else begin
                     hist_bin   <= bin_next;
                     hist_count <= counter[bin_next];
                  end
               end
            end
            DONE: begin
               done     <= 1'b0;
               hist_bin <= 4'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist -- randomized self-checking bench for lbp_hist. A behavioural
// memory answers reads one cycle late. The expected histogram is counted
// directly from the memory contents over the interior pixels.
module tb_lbp_hist;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [5:0] lbp_rd_addr;
   logic       lbp_rd_req;
   logic [7:0] lbp_rd_data;
   logic       hist_valid;
   logic [3:0] hist_bin;
   logic [5:0] hist_count;
   logic       hist_ready;
   logic       done;

   logic [7:0] mem [64];
   int         tests = 0;
   int         fails = 0;
   int         done_cnt = 0;
   int         cycle = 0;
   int         addr_q[$];
   int         cyc_q[$];

   lbp_hist dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .lbp_rd_addr (lbp_rd_addr),
      .lbp_rd_req  (lbp_rd_req),
      .lbp_rd_data (lbp_rd_data),
      .hist_valid  (hist_valid),
      .hist_bin    (hist_bin),
      .hist_count  (hist_count),
      .hist_ready  (hist_ready),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Memory model: a registered request returns its data on the next cycle.
   // Otherwise the bus carries garbage, so that a timing slip in the DUT shows up.
   always @(posedge clk) begin
      if (lbp_rd_req) lbp_rd_data <= mem[lbp_rd_addr];
      else            lbp_rd_data <= 8'($urandom);
   end

   // Monitor: reads stay on interior pixels, and the handshake phases never overlap.
   always @(negedge clk) begin
      cycle++;
      if (!reset) begin
         if (done) done_cnt++;
         if (lbp_rd_req) begin
            addr_q.push_back(int'(lbp_rd_addr));
            cyc_q.push_back(cycle);
            tests++;
            if (lbp_rd_addr[2:0] == 3'd0 || lbp_rd_addr[2:0] == 3'd7 ||
                lbp_rd_addr[5:3] == 3'd0 || lbp_rd_addr[5:3] == 3'd7) begin
               fails++;
               $display("FAIL border_read: addr=%0d required interior", lbp_rd_addr);
            end
         end
         if (hist_valid && (lbp_rd_req || done)) begin
            tests++;
            fails++;
            $display("FAIL valid_outside_output: hist_valid=1 req=%0b done=%0b required no overlap",
                     lbp_rd_req, done);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // One full pass checked against the reference histogram. stall_bin < 0 means
   // no stall. restart re-pulses start during READ and again during OUTPUT.
   task automatic run_pass(input string name, input int stall_bin, input bit restart);
      int exp_h[16];
      int exp_addr[$];
      int base_done;
      int sum;
      int n;
      bit ok;
      for (int i = 0; i < 16; i++) exp_h[i] = 0;
      for (int y = 1; y <= 6; y++)
         for (int x = 1; x <= 6; x++) begin
            exp_h[mem[y * 8 + x] / 16]++;
            exp_addr.push_back(y * 8 + x);
         end
      addr_q.delete();
      cyc_q.delete();
      base_done = done_cnt;
      sum = 0;
      pulse_start();
      if (restart) begin
         repeat (10) @(negedge clk);
         pulse_start();
      end
      n = 0;
      while (!hist_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!hist_valid) begin
         fails++;
         $display("FAIL %s first_valid: hist_valid=%0b required 1 within 200 cycles", name, hist_valid);
         return;
      end
      for (int b = 0; b < 16; b++) begin
         if (b > 0) @(negedge clk);
         tests++;
         if (hist_valid !== 1'b1 || hist_bin !== 4'(b) || hist_count !== 6'(exp_h[b])) begin
            fails++;
            $display("FAIL %s bin%0d: valid=%0b bin=%0d count=%0d required valid=1 bin=%0d count=%0d",
                     name, b, hist_valid, hist_bin, hist_count, b, exp_h[b]);
         end
         sum += int'(hist_count);
         if (restart && b == 5) start = 1'b1;
         if (restart && b == 6) start = 1'b0;
         if (b == stall_bin) begin
            hist_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               tests++;
               if (hist_valid !== 1'b1 || hist_bin !== 4'(b) || hist_count !== 6'(exp_h[b])) begin
                  fails++;
                  $display("FAIL %s stall%0d: valid=%0b bin=%0d count=%0d required valid=1 bin=%0d count=%0d",
                           name, k, hist_valid, hist_bin, hist_count, b, exp_h[b]);
               end
            end
            hist_ready = 1'b1;
         end
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b1 || hist_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s done_pulse: done=%0b valid=%0b required done=1 valid=0", name, done, hist_valid);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL %s done_width: done=%0b required 0", name, done);
      end
      repeat (50) @(negedge clk);
      tests++;
      if (done_cnt - base_done != 1) begin
         fails++;
         $display("FAIL %s done_count: %0d pulses required 1", name, done_cnt - base_done);
      end
      tests++;
      if (sum != 36) begin
         fails++;
         $display("FAIL %s count_sum: %0d required 36", name, sum);
      end
      ok = (addr_q.size() == 36);
      if (ok)
         for (int i = 0; i < 36; i++) begin
            if (addr_q[i] != exp_addr[i]) ok = 1'b0;
            if (i > 0 && cyc_q[i] != cyc_q[i - 1] + 1) ok = 1'b0;
         end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s read_sequence: %0d requests (first=%0d) required 36 contiguous at 9..54",
                  name, addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      hist_ready = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (lbp_rd_addr !== 6'd0 || lbp_rd_req !== 1'b0 || hist_valid !== 1'b0 ||
          hist_bin !== 4'd0 || hist_count !== 6'd0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_values: addr=%0d req=%0b valid=%0b bin=%0d count=%0d done=%0b required all 0",
                  lbp_rd_addr, lbp_rd_req, hist_valid, hist_bin, hist_count, done);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_all_zero();
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      run_pass("all_zero", -1, 1'b0);
   endtask

   task automatic test_coord_pattern();
      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 2);
      run_pass("coord_pattern", -1, 1'b0);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_pass("stall_bin3", 3, 1'b0);
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_pass("start_ignored", -1, 1'b1);
   endtask

   task automatic test_reset_abort();
      int n;
      bit quiet;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      addr_q.delete();
      pulse_start();
      n = 0;
      while (addr_q.size() < 20 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (addr_q.size() < 20) begin
         fails++;
         $display("FAIL reset_abort wait20: %0d reads required 20", addr_q.size());
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (lbp_rd_addr !== 6'd0 || lbp_rd_req !== 1'b0 || hist_valid !== 1'b0 ||
          hist_bin !== 4'd0 || hist_count !== 6'd0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_abort outputs: addr=%0d req=%0b valid=%0b bin=%0d count=%0d done=%0b required all 0",
                  lbp_rd_addr, lbp_rd_req, hist_valid, hist_bin, hist_count, done);
      end
      reset = 1'b0;
      quiet = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (hist_valid || done || lbp_rd_req) quiet = 1'b0;
      end
      tests++;
      if (!quiet) begin
         fails++;
         $display("FAIL reset_abort quiet: activity after abort required none");
      end
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_pass("after_reset", -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255) & 8'h3F | 8'(r << 6));
         run_pass($sformatf("back_to_back%0d", r), int'($urandom_range(0, 15)), 1'b0);
      end
   endtask

   initial begin
      lbp_rd_data = 8'h00;
      test_reset();
      test_all_zero();
      test_coord_pattern();
      test_stall();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
